// File: rtl/commit_trace_buf.sv
// commit_trace_buf: classifies one committed instruction per clock into a
// trace record and buffers it in a small FIFO for a downstream consumer.
// Tracks instruction and cycle counters, counts records lost to a full FIFO,
// and stops capturing once a halting instruction commits.
// Optional build macro: COMMIT_TRACE_NOP_FILTER_EN -- when defined, NOP
// records still advance inst_count but are never stored and never dropped.
module commit_trace_buf #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] inst,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              halt,
  input  logic [REG_W-1:0]  write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [2:0]        rd_kind,
  output logic [31:0]       rd_inum,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_val,
  output logic [DATA_W-1:0] rd_addr,
  output logic [REG_W-1:0]  rd_reg,
  output logic [31:0]       inst_count,
  output logic [31:0]       cycle_count,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic              halted,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] KIND_NOP  = 3'd0;
  localparam logic [2:0] KIND_REG  = 3'd1;
  localparam logic [2:0] KIND_LD   = 3'd2;
  localparam logic [2:0] KIND_STU  = 3'd3;
  localparam logic [2:0] KIND_ST   = 3'd4;
  localparam logic [2:0] KIND_HALT = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_DONE
  } state_t;

  state_t state_q;

  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instCount_q, cycleCount_q;
  logic             overflow_q;
  logic [15:0]      dropCount_q;

  logic [2:0]        kindMem_q [DEPTH];
  logic [31:0]       inumMem_q [DEPTH];
  logic [DATA_W-1:0] pcMem_q   [DEPTH];
  logic [DATA_W-1:0] valMem_q  [DEPTH];
  logic [DATA_W-1:0] addrMem_q [DEPTH];
  logic [REG_W-1:0]  regMem_q  [DEPTH];

  logic [2:0]        recKind;
  logic [DATA_W-1:0] recVal, recAddr;
  logic [REG_W-1:0]  recReg;

  logic capture, pushReq, fifoValid, fifoFull, pop, pushOk, dropEvt;

  // The instruction word carries nothing the trace records need; it is kept
  // on the port list for interface compatibility and deliberately unconsumed.
  logic unusedInst;
  assign unusedInst = ^inst;

  // Classify the committing instruction and select the fields its kind keeps.
  always_comb begin
    recKind = KIND_NOP;
    recVal  = '0;
    recAddr = '0;
    recReg  = '0;
    if (halt) begin
      recKind = KIND_HALT;
    end else if (reg_write && mem_write) begin
      recKind = KIND_STU;
      recVal  = write_data;
      recAddr = mem_addr;
      recReg  = write_reg;
    end else if (reg_write && mem_read) begin
      recKind = KIND_LD;
      recVal  = write_data;
      recAddr = mem_addr;
      recReg  = write_reg;
    end else if (reg_write) begin
      recKind = KIND_REG;
      recVal  = write_data;
      recReg  = write_reg;
    end else if (mem_write) begin
      recKind = KIND_ST;
      recVal  = mem_data;
      recAddr = mem_addr;
    end
  end

  assign capture = (state_q == ST_RUN);

`ifdef COMMIT_TRACE_NOP_FILTER_EN
  assign pushReq = capture && (recKind != KIND_NOP);
`else
  assign pushReq = capture;
`endif

  assign fifoValid = (count_q != '0);
  assign fifoFull  = (count_q == CNT_W'(DEPTH));
  assign pop       = fifoValid && rd_ready;
  // A full FIFO still takes a record when the head leaves in the same cycle.
  assign pushOk    = pushReq && (!fifoFull || pop);
  assign dropEvt   = pushReq && fifoFull && !pop;

  // Occupancy next-state: separate from pointers so full and empty differ.
  always_comb begin
    count_d = count_q;
    if (pushOk && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!pushOk && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Record storage; contents need no reset because occupancy gates the reads.
  always_ff @(posedge clk) begin
    if (!rst && pushOk) begin
      kindMem_q[wrPtr_q] <= recKind;
      inumMem_q[wrPtr_q] <= instCount_q;
      pcMem_q[wrPtr_q]   <= pc;
      valMem_q[wrPtr_q]  <= recVal;
      addrMem_q[wrPtr_q] <= recAddr;
      regMem_q[wrPtr_q]  <= recReg;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)    rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Capture state machine: a halt (even a dropped one) ends capture, then
  // wait for the consumer to drain everything before reporting done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN:    if (halt) state_q <= ST_HALTED;
        ST_HALTED: if (count_q == '0) state_q <= ST_DONE;
        ST_DONE:   state_q <= ST_DONE;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  // Running counters: instructions only while capturing, cycles always.
  always_ff @(posedge clk) begin
    if (rst) begin
      instCount_q  <= '0;
      cycleCount_q <= '0;
    end else begin
      cycleCount_q <= cycleCount_q + 32'd1;
      if (capture) instCount_q <= instCount_q + 32'd1;
    end
  end

  // Loss tracking: sticky flag plus a count that stops at its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      dropCount_q <= '0;
    end else if (dropEvt) begin
      overflow_q <= 1'b1;
      if (dropCount_q != 16'hFFFF) dropCount_q <= dropCount_q + 16'd1;
    end
  end

  assign rd_valid    = fifoValid;
  assign rd_kind     = fifoValid ? kindMem_q[rdPtr_q] : '0;
  assign rd_inum     = fifoValid ? inumMem_q[rdPtr_q] : '0;
  assign rd_pc       = fifoValid ? pcMem_q[rdPtr_q]   : '0;
  assign rd_val      = fifoValid ? valMem_q[rdPtr_q]  : '0;
  assign rd_addr     = fifoValid ? addrMem_q[rdPtr_q] : '0;
  assign rd_reg      = fifoValid ? regMem_q[rdPtr_q]  : '0;
  assign inst_count  = instCount_q;
  assign cycle_count = cycleCount_q;
  assign overflow    = overflow_q;
  assign drop_count  = dropCount_q;
  assign halted      = (state_q != ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed testbench for commit_trace_buf with default parameters.
// Honours COMMIT_TRACE_NOP_FILTER_EN when the design is built with it.
module tb_commit_trace_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc, inst, write_data, mem_addr, mem_data;
  logic        reg_write, mem_read, mem_write, halt, rd_ready;
  logic [2:0]  write_reg;
  logic        rd_valid;
  logic [2:0]  rd_kind;
  logic [31:0] rd_inum;
  logic [15:0] rd_pc, rd_val, rd_addr;
  logic [2:0]  rd_reg;
  logic [31:0] inst_count, cycle_count;
  logic        overflow;
  logic [15:0] drop_count;
  logic        halted, done;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  commit_trace_buf dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .halt(halt),
    .write_reg(write_reg), .write_data(write_data), .mem_addr(mem_addr), .mem_data(mem_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_kind(rd_kind), .rd_inum(rd_inum),
    .rd_pc(rd_pc), .rd_val(rd_val), .rd_addr(rd_addr), .rd_reg(rd_reg),
    .inst_count(inst_count), .cycle_count(cycle_count), .overflow(overflow),
    .drop_count(drop_count), .halted(halted), .done(done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic clearInputs();
    pc = '0; inst = '0; write_data = '0; mem_addr = '0; mem_data = '0;
    reg_write = 0; mem_read = 0; mem_write = 0; halt = 0; write_reg = '0;
  endtask

  task automatic doReset();
    clearInputs();
    rd_ready = 0;
    rst = 1;
    cycle();
    rst = 0;
    edges = 0;
  endtask

  task automatic applyStimulus(input logic rw, input logic mr, input logic mw,
                               input logic h, input logic [2:0] wr,
                               input logic [15:0] wd, input logic [15:0] ma,
                               input logic [15:0] md, input logic [15:0] p);
    reg_write = rw; mem_read = mr; mem_write = mw; halt = h; write_reg = wr;
    write_data = wd; mem_addr = ma; mem_data = md; pc = p; inst = p ^ 16'h5A5A;
    cycle();
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got=%0d want=0", rd_valid); end
    checks++; if (rd_kind !== 3'd0 || rd_val !== 16'd0 || rd_inum !== 32'd0) begin errors++; $display("[TB] FAIL reset_rd_fields got kind=%0d val=%h inum=%0d want 0", rd_kind, rd_val, rd_inum); end
    checks++; if (inst_count !== 32'd0 || cycle_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters got inst=%0d cyc=%0d want 0", inst_count, cycle_count); end
    checks++; if (overflow !== 1'b0 || drop_count !== 16'd0 || halted !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got ovf=%0d drop=%0d halted=%0d done=%0d want 0", overflow, drop_count, halted, done); end
  endtask

  task automatic test_reg_record();
    doReset();
    applyStimulus(1, 0, 0, 0, 3'd5, 16'h1234, 16'h0055, 16'h0077, 16'h0002);
    checks++; if (rd_valid !== 1'b1 || rd_kind !== 3'd1) begin errors++; $display("[TB] FAIL reg_kind got valid=%0d kind=%0d want 1/1", rd_valid, rd_kind); end
    checks++; if (rd_reg !== 3'd5 || rd_val !== 16'h1234 || rd_inum !== 32'd0) begin errors++; $display("[TB] FAIL reg_fields got reg=%0d val=%h inum=%0d want 5/1234/0", rd_reg, rd_val, rd_inum); end
    checks++; if (rd_pc !== 16'h0002 || rd_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reg_pc_addr got pc=%h addr=%h want 0002/0000", rd_pc, rd_addr); end
  endtask

  task automatic test_kinds();
    doReset();
    applyStimulus(1, 0, 1, 0, 3'd2, 16'h0042, 16'h0040, 16'hBEEF, 16'h0004);
    checks++; if (rd_kind !== 3'd3 || rd_addr !== 16'h0040 || rd_val !== 16'h0042 || rd_reg !== 3'd2) begin errors++; $display("[TB] FAIL stu_fields got kind=%0d addr=%h val=%h reg=%0d want 3/0040/0042/2", rd_kind, rd_addr, rd_val, rd_reg); end
    rd_ready = 1;
    applyStimulus(1, 1, 0, 0, 3'd6, 16'h7777, 16'h0080, 16'h1111, 16'h0006);
    checks++; if (rd_kind !== 3'd2 || rd_addr !== 16'h0080 || rd_val !== 16'h7777 || rd_reg !== 3'd6 || rd_inum !== 32'd1) begin errors++; $display("[TB] FAIL ld_fields got kind=%0d addr=%h val=%h reg=%0d inum=%0d want 2/0080/7777/6/1", rd_kind, rd_addr, rd_val, rd_reg, rd_inum); end
    applyStimulus(0, 0, 1, 0, 3'd2, 16'h0042, 16'h00C0, 16'hBEEF, 16'h0008);
    checks++; if (rd_kind !== 3'd4 || rd_addr !== 16'h00C0 || rd_val !== 16'hBEEF || rd_reg !== 3'd0 || rd_inum !== 32'd2) begin errors++; $display("[TB] FAIL st_fields got kind=%0d addr=%h val=%h reg=%0d inum=%0d want 4/00C0/BEEF/0/2", rd_kind, rd_addr, rd_val, rd_reg, rd_inum); end
    applyStimulus(0, 1, 0, 0, 3'd3, 16'h9999, 16'h0100, 16'h2222, 16'h000A);
`ifdef COMMIT_TRACE_NOP_FILTER_EN
    checks++; if (rd_valid !== 1'b0 || inst_count !== 32'd4) begin errors++; $display("[TB] FAIL nop_filtered got valid=%0d inst=%0d want 0/4", rd_valid, inst_count); end
`else
    checks++; if (rd_valid !== 1'b1 || rd_kind !== 3'd0 || rd_val !== 16'd0 || rd_addr !== 16'd0 || rd_reg !== 3'd0 || rd_inum !== 32'd3) begin errors++; $display("[TB] FAIL nop_fields got valid=%0d kind=%0d val=%h addr=%h reg=%0d inum=%0d want 1/0/0/0/0/3", rd_valid, rd_kind, rd_val, rd_addr, rd_reg, rd_inum); end
`endif
  endtask

  task automatic test_overflow();
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 3'd1, 16'(i), 16'd0, 16'd0, 16'(2 * i));
    checks++; if (overflow !== 1'b1 || drop_count !== 16'd4) begin errors++; $display("[TB] FAIL overflow got ovf=%0d drop=%0d want 1/4", overflow, drop_count); end
    checks++; if (inst_count !== 32'd20) begin errors++; $display("[TB] FAIL overflow_inst got %0d want 20", inst_count); end
    checks++; if (rd_valid !== 1'b1 || rd_inum !== 32'd0 || rd_val !== 16'd0) begin errors++; $display("[TB] FAIL overflow_head got valid=%0d inum=%0d val=%h want 1/0/0000", rd_valid, rd_inum, rd_val); end
  endtask

  // Continues straight from the full FIFO left by test_overflow.
  task automatic test_full_pop();
    logic [2:0]  lastKind;
    logic [31:0] firstInum, lastInum, prevInum;
    logic [15:0] lastVal, prevVal;
    int pops = 0;
    lastKind = '0; firstInum = '0; lastInum = '0; prevInum = '0; lastVal = '0; prevVal = '0;
    rd_ready = 1;
    applyStimulus(1, 0, 0, 0, 3'd7, 16'hAAAA, 16'd0, 16'd0, 16'h0100);
    checks++; if (drop_count !== 16'd4 || inst_count !== 32'd21 || rd_inum !== 32'd1) begin errors++; $display("[TB] FAIL full_pop got drop=%0d inst=%0d head=%0d want 4/21/1", drop_count, inst_count, rd_inum); end
    applyStimulus(0, 0, 0, 1, 3'd0, 16'd0, 16'd0, 16'd0, 16'h0102);
    checks++; if (drop_count !== 16'd4 || halted !== 1'b1 || rd_inum !== 32'd2) begin errors++; $display("[TB] FAIL full_pop_halt got drop=%0d halted=%0d head=%0d want 4/1/2", drop_count, halted, rd_inum); end
    clearInputs();
    for (int i = 0; i < 40 && rd_valid; i++) begin
      if (pops == 0) firstInum = rd_inum;
      prevInum = lastInum; prevVal = lastVal;
      lastKind = rd_kind; lastInum = rd_inum; lastVal = rd_val;
      pops++;
      cycle();
    end
    checks++; if (pops != 16 || firstInum !== 32'd2) begin errors++; $display("[TB] FAIL full_pop_drain got pops=%0d first=%0d want 16/2", pops, firstInum); end
    checks++; if (lastKind !== 3'd5 || lastInum !== 32'd21 || prevInum !== 32'd20 || prevVal !== 16'hAAAA) begin errors++; $display("[TB] FAIL full_pop_tail got kind=%0d inum=%0d prev=%0d prevVal=%h want 5/21/20/AAAA", lastKind, lastInum, prevInum, prevVal); end
    for (int i = 0; i < 10 && !done; i++) cycle();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL full_pop_done got %0d want 1 (timeout)", done); end
  endtask

  task automatic test_halt();
    doReset();
    rd_ready = 1;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 3'd3, 16'(16'h10 + i), 16'd0, 16'd0, 16'(4 * i));
    applyStimulus(1, 0, 1, 1, 3'd4, 16'hFFFF, 16'h00AA, 16'h00BB, 16'h0010);
    checks++; if (rd_kind !== 3'd5 || rd_inum !== 32'd3 || rd_pc !== 16'h0010) begin errors++; $display("[TB] FAIL halt_record got kind=%0d inum=%0d pc=%h want 5/3/0010", rd_kind, rd_inum, rd_pc); end
    checks++; if (rd_val !== 16'd0 || rd_addr !== 16'd0 || rd_reg !== 3'd0) begin errors++; $display("[TB] FAIL halt_fields got val=%h addr=%h reg=%0d want 0", rd_val, rd_addr, rd_reg); end
    checks++; if (halted !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL halt_flags got halted=%0d done=%0d want 1/0", halted, done); end
    reg_write = 1; write_data = 16'h4321;
    for (int i = 0; i < 10 && !done; i++) cycle();
    checks++; if (done !== 1'b1 || halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_done got done=%0d halted=%0d want 1/1 (timeout)", done, halted); end
    applyStimulus(1, 0, 0, 0, 3'd1, 16'h5555, 16'd0, 16'd0, 16'h0020);
    checks++; if (rd_valid !== 1'b0 || inst_count !== 32'd4) begin errors++; $display("[TB] FAIL halt_ignore got valid=%0d inst=%0d want 0/4", rd_valid, inst_count); end
    checks++; if (cycle_count !== 32'(edges) || done !== 1'b1) begin errors++; $display("[TB] FAIL halt_cycles got cyc=%0d done=%0d want %0d/1", cycle_count, done, edges); end
  endtask

  task automatic test_dropped_halt();
    int pops = 0;
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 0, 3'd2, 16'(i), 16'd0, 16'd0, 16'(i));
    applyStimulus(0, 0, 0, 1, 3'd0, 16'd0, 16'd0, 16'd0, 16'h0030);
    checks++; if (halted !== 1'b1 || overflow !== 1'b1 || drop_count !== 16'd1 || inst_count !== 32'd17) begin errors++; $display("[TB] FAIL drop_halt got halted=%0d ovf=%0d drop=%0d inst=%0d want 1/1/1/17", halted, overflow, drop_count, inst_count); end
    clearInputs();
    rd_ready = 1;
    for (int i = 0; i < 40 && rd_valid; i++) begin
      pops++;
      cycle();
    end
    for (int i = 0; i < 10 && !done; i++) cycle();
    checks++; if (pops != 16 || done !== 1'b1) begin errors++; $display("[TB] FAIL drop_halt_drain got pops=%0d done=%0d want 16/1", pops, done); end
  endtask

  task automatic test_reset_mid();
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 3'd1, 16'(16'h100 + i), 16'd0, 16'd0, 16'(i));
    checks++; if (rd_valid !== 1'b1 || inst_count !== 32'd5) begin errors++; $display("[TB] FAIL mid_prefill got valid=%0d inst=%0d want 1/5", rd_valid, inst_count); end
    rst = 1;
    applyStimulus(1, 0, 0, 0, 3'd1, 16'h0BAD, 16'd0, 16'd0, 16'h0040);
    rst = 0;
    checks++; if (rd_valid !== 1'b0 || rd_kind !== 3'd0 || rd_val !== 16'd0 || inst_count !== 32'd0 || cycle_count !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset got valid=%0d kind=%0d val=%h inst=%0d cyc=%0d want 0", rd_valid, rd_kind, rd_val, inst_count, cycle_count); end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 3'd0, 16'd0, 16'd0, 16'd0, 16'(i));
`ifdef COMMIT_TRACE_NOP_FILTER_EN
    checks++; if (rd_valid !== 1'b0 || inst_count !== 32'd4) begin errors++; $display("[TB] FAIL mid_nops got valid=%0d inst=%0d want 0/4", rd_valid, inst_count); end
`else
    checks++; if (rd_valid !== 1'b1 || rd_kind !== 3'd0 || rd_inum !== 32'd0 || inst_count !== 32'd4) begin errors++; $display("[TB] FAIL mid_nops got valid=%0d kind=%0d inum=%0d inst=%0d want 1/0/0/4", rd_valid, rd_kind, rd_inum, inst_count); end
`endif
  endtask

  // Scenario sequence and summary.
  initial begin
    clearInputs();
    rd_ready = 0;
    rst = 1;
    test_reset();
    test_reg_record();
    test_kinds();
    test_overflow();
    test_full_pop();
    test_halt();
    test_dropped_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_trace_buf.md
COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

Interface
REQ-001 Parameter DATA_W, default 16, width of PC, data and address fields.
REQ-002 Parameter REG_W, default 3, width of register-select field.
REQ-003 Parameter DEPTH, default 16, record FIFO entries; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pc, inst  input  DATA_W each  committing instruction address and word.
REQ-007 reg_write, mem_read, mem_write, halt  input  1 each  commit qualifiers.
REQ-008 write_reg  input  REG_W  destination register.
REQ-009 write_data, mem_addr, mem_data  input  DATA_W each  register write value, memory address, store data.
REQ-010 rd_ready  input  1  consumer accepts head record.
REQ-011 rd_valid  output  1  head record present.
REQ-012 rd_kind  output  3  record kind: 0 NOP, 1 REG, 2 LD, 3 STU, 4 ST, 5 HALT.
REQ-013 rd_inum  output  32  instruction number; rd_pc, rd_val, rd_addr  output  DATA_W; rd_reg  output  REG_W.
REQ-014 inst_count, cycle_count  output  32 each  running counters.
REQ-015 overflow  output  1  sticky: at least one record dropped; drop_count  output  16  saturating dropped-record count.
REQ-016 halted  output  1  halt captured; done  output  1  halted and FIFO drained.

Function
REQ-017 One record classified per clk in state RUN: halt -> HALT (highest priority); else reg_write&mem_write -> STU; else reg_write&mem_read -> LD; else reg_write -> REG; else mem_write -> ST; else NOP.
REQ-018 Record fields: rd_val = write_data for REG/LD/STU, mem_data for ST, 0 otherwise; rd_addr = mem_addr for LD/STU/ST, 0 otherwise; rd_reg = write_reg for REG/LD/STU, 0 otherwise.
REQ-019 rd_inum = inst_count value before the increment caused by that record; inst_count increments by 1 for every record classified in RUN, buffered or dropped.
REQ-020 cycle_count increments every non-reset cycle in all states, wrapping at 2^32.
REQ-021 States: RUN -> HALTED on cycle a HALT record is classified; HALTED -> DONE when FIFO empty; DONE held until rst.
REQ-022 In HALTED and DONE, no records captured, inst_count frozen; inputs ignored.
REQ-023 Record written at end of classification cycle; visible on rd_* one cycle later (latency 1).
REQ-024 Pop occurs on rd_valid & rd_ready; rd_* show head; rd_* undefined-free: zero when empty.
REQ-025 Full and pop same cycle: new record accepted, no drop.
REQ-026 Full and no pop: new record dropped, overflow set, drop_count +1 saturating at 0xFFFF; a dropped HALT still moves state to HALTED.
REQ-027 Empty with push and rd_ready same cycle: no bypass; record appears next cycle.
REQ-028 Pointers wrap modulo DEPTH; occupancy counter distinguishes full from empty.
REQ-029 halted high in HALTED and DONE; done high only in DONE.

Reset
REQ-030 On rst: state RUN, FIFO empty, rd_valid 0, all rd_* 0, inst_count 0, cycle_count 0, overflow 0, drop_count 0, halted 0, done 0.
REQ-031 rst mid-operation discards all buffered records; the cycle with rst high classifies nothing.

Configuration
REQ-032 Macro COMMIT_TRACE_NOP_FILTER_EN: when defined, NOP records are counted (inst_count increments) but never written to the FIFO and never cause drops; when undefined, NOP records are buffered like all others.

Verification
REQ-033 Reset, then reg_write=1, write_reg=5, write_data=0x1234, pc=0x0002 one cycle -> next cycle rd_valid=1, rd_kind=1, rd_reg=5, rd_val=0x1234, rd_inum=0.
REQ-034 reg_write=1, mem_write=1, mem_addr=0x0040, mem_data=0xBEEF, write_data=0x0042 -> rd_kind=3, rd_addr=0x0040, rd_val=0x0042.
REQ-035 rd_ready=0, DEPTH=16, 20 REG commits -> 16 buffered, overflow=1, drop_count=4, inst_count=20.
REQ-036 Full FIFO, rd_ready=1 with one more commit -> no drop, occupancy stays 16.
REQ-037 halt=1 at pc=0x0010 after 3 commits, rd_ready=1 -> HALT record rd_inum=3, halted=1, done=1 after drain, later inputs ignored.
REQ-038 rst asserted with 5 records buffered -> next cycle rd_valid=0, counters 0; with COMMIT_TRACE_NOP_FILTER_EN, 4 NOP cycles -> rd_valid stays 0, inst_count=4.
